// File: rtl/fft4_pkg.sv
// fft4_pkg: default sample width, internal stage widths and saturating narrowing.
package fft4_pkg;
  localparam int FFT_W = 16;
  localparam int FFT_W1 = FFT_W + 1;
  localparam int FFT_W2 = FFT_W + 2;
  // Clamp a signed value to the w-bit two's-complement range.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/fft_bfly.sv
// fft_bfly: complex radix-2 butterfly, s = a + b and d = a - b, one bit of growth.
module fft_bfly #(parameter int N = 16) (
  input  logic signed [N-1:0] a_re,
  input  logic signed [N-1:0] a_im,
  input  logic signed [N-1:0] b_re,
  input  logic signed [N-1:0] b_im,
  output logic signed [N:0]   s_re,
  output logic signed [N:0]   s_im,
  output logic signed [N:0]   d_re,
  output logic signed [N:0]   d_im
);
  assign s_re = {a_re[N-1], a_re} + {b_re[N-1], b_re};
  assign s_im = {a_im[N-1], a_im} + {b_im[N-1], b_im};
  assign d_re = {a_re[N-1], a_re} - {b_re[N-1], b_re};
  assign d_im = {a_im[N-1], a_im} - {b_im[N-1], b_im};
endmodule

// File: rtl/fft4.sv
// fft4: two-stage pipelined radix-2 DIT 4-point forward DFT with saturated outputs.
module fft4 import fft4_pkg::*; #(parameter int W = FFT_W) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] x0_re,
  input  logic signed [W-1:0] x0_im,
  input  logic signed [W-1:0] x1_re,
  input  logic signed [W-1:0] x1_im,
  input  logic signed [W-1:0] x2_re,
  input  logic signed [W-1:0] x2_im,
  input  logic signed [W-1:0] x3_re,
  input  logic signed [W-1:0] x3_im,
  output logic signed [W-1:0] y0_re,
  output logic signed [W-1:0] y0_im,
  output logic signed [W-1:0] y1_re,
  output logic signed [W-1:0] y1_im,
  output logic signed [W-1:0] y2_re,
  output logic signed [W-1:0] y2_im,
  output logic signed [W-1:0] y3_re,
  output logic signed [W-1:0] y3_im
);
  localparam int W1 = W + 1;
  localparam int W2 = W + 2;
  logic signed [W1-1:0] a0c_re, a0c_im, a1c_re, a1c_im, b0c_re, b0c_im, b1c_re, b1c_im;
  logic signed [W1-1:0] a0_re, a0_im, a1_re, a1_im, b0_re, b0_im, b1_re, b1_im;
  logic signed [W2-1:0] e_re, e_im, f_re, f_im, p_re, p_im, m_re, m_im;
  function automatic logic signed [W-1:0] nar(input logic signed [W2-1:0] v);
    return W'(sat(64'(v), W));
  endfunction
  fft_bfly #(.N(W)) u_s1a (
    .a_re(x0_re), .a_im(x0_im), .b_re(x2_re), .b_im(x2_im),
    .s_re(a0c_re), .s_im(a0c_im), .d_re(a1c_re), .d_im(a1c_im)
  );
  fft_bfly #(.N(W)) u_s1b (
    .a_re(x1_re), .a_im(x1_im), .b_re(x3_re), .b_im(x3_im),
    .s_re(b0c_re), .s_im(b0c_im), .d_re(b1c_re), .d_im(b1c_im)
  );
  fft_bfly #(.N(W1)) u_s2a (
    .a_re(a0_re), .a_im(a0_im), .b_re(b0_re), .b_im(b0_im),
    .s_re(e_re), .s_im(e_im), .d_re(f_re), .d_im(f_im)
  );
  // -j*b1 = b1_im - j*b1_re: feed b1 swapped, then pick sum/diff per component.
  fft_bfly #(.N(W1)) u_s2b (
    .a_re(a1_re), .a_im(a1_im), .b_re(b1_im), .b_im(b1_re),
    .s_re(p_re), .s_im(p_im), .d_re(m_re), .d_im(m_im)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {a0_re, a0_im, a1_re, a1_im, b0_re, b0_im, b1_re, b1_im} <= '0;
      {y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im} <= '0;
    end else begin
      {a0_re, a0_im, a1_re, a1_im} <= {a0c_re, a0c_im, a1c_re, a1c_im};
      {b0_re, b0_im, b1_re, b1_im} <= {b0c_re, b0c_im, b1c_re, b1c_im};
      y0_re <= nar(e_re);
      y0_im <= nar(e_im);
      y2_re <= nar(f_re);
      y2_im <= nar(f_im);
      y1_re <= nar(p_re);
      y1_im <= nar(m_im);
      y3_re <= nar(m_re);
      y3_im <= nar(p_im);
    end
  end
endmodule

// File: tb/tb_fft4.sv
// tb_fft4: random and directed vectors against a direct-summation DFT model.
module tb_fft4;
  localparam int W = 16;
  localparam int VW = 8 * W;
  logic clk = 0;
  logic reset = 1;
  logic signed [W-1:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;
  logic signed [W-1:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;
  logic [VW-1:0] yv;
  logic [VW-1:0] q[$];
  int total = 0;
  int bad = 0;
  assign yv = {y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im};
  always #5 clk = ~clk;
  fft4 #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .x2_re(x2_re), .x2_im(x2_im), .x3_re(x3_re), .x3_im(x3_im),
    .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
    .y2_re(y2_re), .y2_im(y2_im), .y3_re(y3_re), .y3_im(y3_im)
  );
  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] clip(input int v);
    int hi;
    hi = (1 << (W - 1)) - 1;
    return W'((v > hi) ? hi : (v < -hi - 1) ? -hi - 1 : v);
  endfunction
  // Y[k] = sum_n x[n] * (-j)^(n*k), summed exactly then clamped.
  function automatic logic [VW-1:0] dft(input logic [VW-1:0] xv);
    int xr[4], xi[4];
    logic [VW-1:0] r;
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($signed(xv[VW-1-2*n*W -: W]));
      xi[n] = int'($signed(xv[VW-1-(2*n+1)*W -: W]));
    end
    for (int k = 0; k < 4; k++) begin
      int sr, si;
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin sr += xr[n]; si += xi[n]; end
          1: begin sr += xi[n]; si -= xr[n]; end
          2: begin sr -= xr[n]; si -= xi[n]; end
          default: begin sr -= xi[n]; si += xr[n]; end
        endcase
      end
      r[VW-1-2*k*W -: W] = clip(sr);
      r[VW-1-(2*k+1)*W -: W] = clip(si);
    end
    return r;
  endfunction
  function automatic logic [VW-1:0] mk(input int a, b, c, d, e, f, g, h);
    return {W'(a), W'(b), W'(c), W'(d), W'(e), W'(f), W'(g), W'(h)};
  endfunction
  task automatic drive(input logic [VW-1:0] xv);
    {x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im} = xv;
  endtask
  task automatic step(input string tag, input logic [VW-1:0] xv);
    @(negedge clk);
    if (q.size() == 2) chk(tag, yv, q.pop_front());
    drive(xv);
    q.push_back(dft(xv));
  endtask
  task automatic release_rst();
    @(negedge clk);
    reset = 1;
    drive('0);
    q.delete();
    q.push_back('0);
  endtask
  function automatic logic [W-1:0] rnd_comp();
    int s;
    s = $urandom_range(0, 5);
    return (s == 0) ? 16'h7FFF : (s == 1) ? 16'h8000 : W'($urandom);
  endfunction
  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*W +: W] = rnd_comp();
    return v;
  endfunction
  initial begin
    drive(mk(5, 6, 7, 8, 9, 10, 11, 12));
    #1 reset = 0;
    #1 chk("rst_async", yv, '0);
    repeat (2) @(negedge clk);
    chk("rst_hold", yv, '0);
    release_rst();
    step("post_rst_zero", mk(1, 0, 2, 0, 3, 0, 4, 0));
    step("post_rst_zero", mk(0, 1, 0, 2, 0, 3, 0, 4));
    chk("dft_ref_027", dft(mk(1, 0, 2, 0, 3, 0, 4, 0)), mk(10, 0, -2, 2, -2, 0, -2, -2));
    step("real_ramp", mk(2, 0, -1, 2, 0, 0, 3, -1));
    step("imag_ramp", mk(32767, 32767, -32768, -32768, 32767, -32768, -32768, 32767));
    step("mixed", '0);
    step("extremes", '0);
    chk("extremes_direct", yv, mk(-2, -2, -32768, 32767, 32767, 0, 32767, 32767));
    for (int i = 0; i < 300; i++) step("random", rnd_vec());
    for (int i = 0; i < 5; i++) step("pre_midrst", rnd_vec());
    #2 reset = 0;
    #1 chk("midrst_async", yv, '0);
    @(negedge clk);
    chk("midrst_hold", yv, '0);
    release_rst();
    step("midrst_zero", rnd_vec());
    step("midrst_zero", rnd_vec());
    for (int i = 0; i < 100; i++) step("random2", rnd_vec());
    step("drain", '0);
    step("drain", '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
